vec_exec: RTL and testbench

- Vector execute stage directly downstream of the register file's read ports; consumes the two WIDTH_VECTOR x N operand vectors and the opcode.
- Produces the register-file write-back triple wec/addrc/wdata_c.
- Lane-parallel ops complete in one cycle. Cross-lane reductions run a multi-cycle FSM and stall issue via in_ready.

---
 rtl/vec_exec.sv | 173 +++++++++++++++++
 tb/tb_vec_exec.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_exec.sv
// Vector execute stage: lane-parallel ALU ops complete in one cycle,
// cross-lane reductions (sum/max of op_a) run a multi-cycle FSM and stall issue.
module vec_exec #(
    parameter int WIDTH_ADDR   = 4,
    parameter int WIDTH_VECTOR = 8,
    parameter int N            = 32,
    parameter int WIDTH_OPCODE = 4
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [WIDTH_OPCODE-1:0]           opcode,
    input  logic [WIDTH_ADDR-1:0]             addrc_in,
    input  logic [WIDTH_VECTOR-1:0]           wmask_in,
    input  logic [N-1:0]                      imm,
    input  logic [WIDTH_VECTOR-1:0][N-1:0]    op_a,
    input  logic [WIDTH_VECTOR-1:0][N-1:0]    op_b,
    output logic [WIDTH_VECTOR-1:0]           wec,
    output logic [WIDTH_ADDR-1:0]             addrc,
    output logic [WIDTH_VECTOR-1:0][N-1:0]    wdata_c,
    output logic                              busy,
    output logic                              err
);

    localparam logic [WIDTH_OPCODE-1:0] OP_ADD  = WIDTH_OPCODE'(0);
    localparam logic [WIDTH_OPCODE-1:0] OP_SUB  = WIDTH_OPCODE'(1);
    localparam logic [WIDTH_OPCODE-1:0] OP_AND  = WIDTH_OPCODE'(2);
    localparam logic [WIDTH_OPCODE-1:0] OP_OR   = WIDTH_OPCODE'(3);
    localparam logic [WIDTH_OPCODE-1:0] OP_XOR  = WIDTH_OPCODE'(4);
    localparam logic [WIDTH_OPCODE-1:0] OP_MUL  = WIDTH_OPCODE'(5);
    localparam logic [WIDTH_OPCODE-1:0] OP_NOT  = WIDTH_OPCODE'(6);
    localparam logic [WIDTH_OPCODE-1:0] OP_SHL1 = WIDTH_OPCODE'(7);
    localparam logic [WIDTH_OPCODE-1:0] OP_SHR1 = WIDTH_OPCODE'(8);
    localparam logic [WIDTH_OPCODE-1:0] OP_MAX  = WIDTH_OPCODE'(9);
    localparam logic [WIDTH_OPCODE-1:0] OP_LDI  = WIDTH_OPCODE'(10);
    localparam logic [WIDTH_OPCODE-1:0] OP_RSUM = WIDTH_OPCODE'(11);
    localparam logic [WIDTH_OPCODE-1:0] OP_RMAX = WIDTH_OPCODE'(12);
    localparam logic [WIDTH_OPCODE-1:0] OP_NOP  = WIDTH_OPCODE'(13);

    localparam int CW = (WIDTH_VECTOR > 1) ? $clog2(WIDTH_VECTOR) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RED,
        S_WB
    } state_t;

    state_t                           state_reg;
    logic [WIDTH_VECTOR-1:0][N-1:0]   vec_reg;
    logic [N-1:0]                     acc_reg;
    logic [CW-1:0]                    cnt_reg;
    logic [WIDTH_ADDR-1:0]            raddr_reg;
    logic [WIDTH_VECTOR-1:0]          rmask_reg;
    logic                             rmax_reg;

    logic                             accept;
    logic                             is_lane_op;
    logic                             is_red;
    logic                             is_nop;
    logic                             is_rsvd;
    logic                             addr_zero;
    logic                             err_set;
    logic [WIDTH_VECTOR-1:0][N-1:0]   lane_res;
    logic [N-1:0]                     red_lane;
    logic [N-1:0]                     red_next;
    logic                             red_last;

    assign in_ready   = (state_reg == S_IDLE);
    assign busy       = (state_reg != S_IDLE);
    assign accept     = in_valid && in_ready;

    assign is_lane_op = (opcode <= OP_LDI);
    assign is_red     = (opcode == OP_RSUM) || (opcode == OP_RMAX);
    assign is_nop     = (opcode == OP_NOP);
    assign is_rsvd    = !(is_lane_op || is_red || is_nop);
    assign addr_zero  = (addrc_in == '0);

    // Address 0 is FIFO-mapped: any real write attempt there is flagged.
    assign err_set = accept &&
                     (is_rsvd || ((is_lane_op || is_red) && addr_zero && (wmask_in != '0)));

    generate
        for (genvar gi = 0; gi < WIDTH_VECTOR; gi++) begin : g_lane
            logic [N-1:0] a;
            logic [N-1:0] b;
            logic [N-1:0] res;

            assign a = op_a[gi];
            assign b = op_b[gi];

            always_comb begin
                res = '0;
                case (opcode)
                    OP_ADD:  res = a + b;
                    OP_SUB:  res = a - b;
                    OP_AND:  res = a & b;
                    OP_OR:   res = a | b;
                    OP_XOR:  res = a ^ b;
                    OP_MUL:  res = a * b;
                    OP_NOT:  res = ~a;
                    OP_SHL1: res = a << 1;
                    OP_SHR1: res = a >> 1;
                    OP_MAX:  res = (a > b) ? a : b;
                    OP_LDI:  res = imm;
                    default: res = '0;
                endcase
            end

            assign lane_res[gi] = res;
        end
    endgenerate

    assign red_lane = vec_reg[cnt_reg];
    assign red_next = rmax_reg ? ((red_lane > acc_reg) ? red_lane : acc_reg)
                               : (acc_reg + red_lane);
    assign red_last = (cnt_reg == CW'(WIDTH_VECTOR - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= S_IDLE;
            vec_reg   <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            raddr_reg <= '0;
            rmask_reg <= '0;
            rmax_reg  <= 1'b0;
            wec       <= '0;
            addrc     <= '0;
            wdata_c   <= '0;
            err       <= 1'b0;
        end else begin
            wec <= '0;
            if (err_set) begin
                err <= 1'b1;
            end

            case (state_reg)
                S_IDLE: begin
                    if (accept && is_lane_op) begin
                        wec     <= addr_zero ? '0 : wmask_in;
                        addrc   <= addrc_in;
                        wdata_c <= lane_res;
                    end else if (accept && is_red) begin
                        vec_reg   <= op_a;
                        acc_reg   <= op_a[0];
                        cnt_reg   <= CW'(1);
                        raddr_reg <= addrc_in;
                        rmask_reg <= wmask_in;
                        rmax_reg  <= (opcode == OP_RMAX);
                        // A single-lane vector has nothing left to fold.
                        state_reg <= (WIDTH_VECTOR > 1) ? S_RED : S_WB;
                    end
                end
                S_RED: begin
                    acc_reg <= red_next;
                    cnt_reg <= cnt_reg + CW'(1);
                    if (red_last) begin
                        state_reg <= S_WB;
                    end
                end
                S_WB: begin
                    wec       <= (raddr_reg == '0) ? '0 : rmask_reg;
                    addrc     <= raddr_reg;
                    wdata_c   <= {WIDTH_VECTOR{acc_reg}};
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_exec.sv
// Directed bench for vec_exec: a scoreboard queue holds expected write-backs
// (with their completion cycle); a negedge monitor pops and compares them.
module tb_vec_exec;
    localparam int WA = 4;
    localparam int W  = 8;
    localparam int N  = 32;
    localparam int WO = 4;

    typedef logic [W-1:0][N-1:0] vec_t;
    typedef struct {
        int             cyc;
        logic [W-1:0]   wec;
        logic [WA-1:0]  addr;
        vec_t           data;
    } exp_t;

    logic           clk;
    logic           rstn;
    logic           in_valid;
    logic           in_ready;
    logic [WO-1:0]  opcode;
    logic [WA-1:0]  addrc_in;
    logic [W-1:0]   wmask_in;
    logic [N-1:0]   imm;
    vec_t           op_a;
    vec_t           op_b;
    logic [W-1:0]   wec;
    logic [WA-1:0]  addrc;
    vec_t           wdata_c;
    logic           busy;
    logic           err;

    vec_exec #(.WIDTH_ADDR(WA), .WIDTH_VECTOR(W), .N(N), .WIDTH_OPCODE(WO)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .addrc_in(addrc_in), .wmask_in(wmask_in), .imm(imm),
        .op_a(op_a), .op_b(op_b), .wec(wec), .addrc(addrc), .wdata_c(wdata_c),
        .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    task automatic chk(input string tag, input logic [W*N-1:0] obs, input logic [W*N-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic vec_t bcast(input logic [N-1:0] v);
        vec_t r;
        for (int i = 0; i < W; i++) r[i] = v;
        return r;
    endfunction

    function automatic logic [N-1:0] model(input logic [WO-1:0] op, input logic [N-1:0] a,
                                          input logic [N-1:0] b, input logic [N-1:0] iv);
        logic [N-1:0] r;
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = a * b;
            4'd6:    r = ~a;
            4'd7:    r = {a[N-2:0], 1'b0};
            4'd8:    r = {1'b0, a[N-1:1]};
            4'd9:    r = (a > b) ? a : b;
            4'd10:   r = iv;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Every nonzero wec must match the oldest expected write, in the right cycle.
    always @(negedge clk) begin
        if (rstn === 1'b1 && wec !== '0) begin
            if (sb.size() == 0) begin
                chk("spurious_wec", wec, '0);
            end else begin
                mon_e = sb.pop_front();
                chk("wb_cycle", cyc, mon_e.cyc);
                chk("wb_wec", wec, mon_e.wec);
                chk("wb_addr", addrc, mon_e.addr);
                chk("wb_data", wdata_c, mon_e.data);
            end
        end
    end

    task automatic drive(input logic [WO-1:0] op, input logic [WA-1:0] ad, input logic [W-1:0] m,
                         input vec_t a, input vec_t b, input logic [N-1:0] iv);
        opcode   = op;
        addrc_in = ad;
        wmask_in = m;
        op_a     = a;
        op_b     = b;
        imm      = iv;
        in_valid = 1'b1;
    endtask

    // Issue one single-cycle op; leaves in_valid high so calls chain back to back.
    task automatic lane_op(input logic [WO-1:0] op, input logic [WA-1:0] ad, input logic [W-1:0] m,
                           input vec_t a, input vec_t b, input logic [N-1:0] iv);
        exp_t e;
        chk("issue_in_ready", in_ready, 1'b1);
        drive(op, ad, m, a, b, iv);
        for (int i = 0; i < W; i++) e.data[i] = model(op, a[i], b[i], iv);
        e.cyc  = cyc + 1;
        e.wec  = m;
        e.addr = ad;
        if (op <= 4'd10 && ad != '0 && m != '0) sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Reduction: checks the stall window while holding an unaccepted ADD on the input.
    task automatic red_op(input logic [WO-1:0] op, input logic [WA-1:0] ad, input logic [W-1:0] m,
                          input vec_t a, input logic [N-1:0] result);
        exp_t e;
        chk("red_issue_ready", in_ready, 1'b1);
        drive(op, ad, m, a, '0, '0);
        e.cyc  = cyc + 1 + W;
        e.wec  = m;
        e.addr = ad;
        e.data = bcast(result);
        if (ad != '0 && m != '0) sb.push_back(e);
        @(negedge clk);
        drive(4'd0, 4'd7, 8'hFF, bcast(32'd1), bcast(32'd1), '0);
        for (int i = 0; i < W; i++) begin
            chk("red_stall", in_ready, 1'b0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("red_ready_again", in_ready, 1'b1);
        idle(1);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    vec_t va;
    vec_t vb;

    initial begin
        rstn = 1'b1; in_valid = 1'b0; opcode = '0; addrc_in = '0; wmask_in = '0;
        imm = '0; op_a = '0; op_b = '0;
        #2 rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wec", wec, '0);
        chk("rst_addrc", addrc, '0);
        chk("rst_wdata", wdata_c, '0);
        chk("rst_err", err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        rstn = 1'b1;
        idle(1);

        lane_op(4'd0, 4'd3, 8'hFF, bcast(32'hFFFF_FFFF), bcast(32'd2), '0);
        idle(1);
        chk("wec_after_add", wec, '0);

        lane_op(4'd1, 4'd6, 8'h0F, bcast(32'd5), bcast(32'd7), '0);
        chk("b2b_in_ready", in_ready, 1'b1);
        lane_op(4'd9, 4'd6, 8'h0F, bcast(32'd5), bcast(32'd7), '0);
        chk("b2b_in_ready2", in_ready, 1'b1);
        idle(2);

        for (int op = 0; op <= 10; op++) begin
            for (int i = 0; i < W; i++) begin
                va[i] = $urandom();
                vb[i] = $urandom();
            end
            lane_op(4'(op), 4'($urandom_range(1, 15)), 8'($urandom_range(1, 255)), va, vb, $urandom());
        end
        idle(2);
        chk("err_clean", err, 1'b0);

        for (int i = 0; i < W; i++) va[i] = 32'(i + 1);
        red_op(4'd11, 4'd5, 8'hFF, va, 32'd36);
        red_op(4'd11, 4'd2, 8'hA5, bcast(32'h4000_0000), 32'd0);
        va = bcast(32'd2);
        va[0] = 32'd3; va[1] = 32'h8000_0000; va[2] = 32'd7; va[7] = 32'h7FFF_FFFF;
        red_op(4'd12, 4'd9, 8'h3C, va, 32'h8000_0000);
        va[1] = 32'd1;
        red_op(4'd12, 4'd4, 8'hFF, va, 32'h7FFF_FFFF);
        chk("err_after_red", err, 1'b0);

        lane_op(4'd15, 4'd3, 8'hFF, bcast(32'd1), bcast(32'd1), '0);
        idle(1);
        chk("rsvd15_err", err, 1'b1);

        va[1] = 32'h8000_0000;
        drive(4'd12, 4'd8, 8'hFF, va, '0, '0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_before", busy, 1'b1);
        rstn = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_wec", wec, '0);
        chk("abort_addrc", addrc, '0);
        chk("abort_wdata", wdata_c, '0);
        chk("abort_err", err, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        idle(12);

        lane_op(4'd0, 4'd3, 8'h00, bcast(32'd1), bcast(32'd1), '0);
        idle(1);
        chk("mask0_err", err, 1'b0);

        lane_op(4'd10, 4'd0, 8'hFF, '0, '0, 32'hA5A5_A5A5);
        chk("ldi_a0_wec", wec, '0);
        chk("ldi_a0_err", err, 1'b1);
        lane_op(4'd14, 4'd3, 8'hFF, '0, '0, '0);
        chk("rsvd14_wec", wec, '0);
        chk("rsvd14_err", err, 1'b1);
        lane_op(4'd13, 4'd3, 8'hFF, '0, '0, '0);
        chk("nop_wec", wec, '0);
        lane_op(4'd10, 4'd2, 8'h81, '0, '0, 32'hA5A5_A5A5);
        idle(3);
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
